serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request to begin one addition; sampled only in IDLE or DONE.
REQ-005 Port: a  input  WIDTH  operand A; sampled on the edge that accepts start.
REQ-006 Port: b  input  WIDTH  operand B; sampled on the edge that accepts start.
REQ-007 Port: cin  input  1  carry-in; sampled on the edge that accepts start.
REQ-008 Port: busy  output  1  high while a bit-serial addition is in progress (state RUN).
REQ-009 Port: done  output  1  single-cycle pulse; result on s/c has just been updated.
REQ-010 Port: s  output  WIDTH  registered sum, (a+b+cin) mod 2^WIDTH.
REQ-011 Port: c  output  1  registered carry-out, bit WIDTH of a+b+cin.

Function
REQ-012 Datapath SHALL be one full-adder cell plus a carry flip-flop, processing one bit per clock, LSB first; no WIDTH-wide adder.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-014 IDLE: start=1 at edge -> latch a, b into operand shift registers, carry FF <= cin, bit counter <= 0, go RUN; start=0 -> stay IDLE.
REQ-015 RUN, each edge: sum bit = opA[0]^opB[0]^carry, shifted into internal sum shift register from MSB side; carry FF <= majority(opA[0],opB[0],carry); operands shift right one; counter increments.
REQ-016 RUN, edge with counter == WIDTH-1: last bit processed, s <= full internal sum, c <= final carry, go DONE.
REQ-017 Latency: start accepted at edge t0 -> busy high cycles t0..t0+WIDTH-1, done high for exactly the one cycle after edge t0+WIDTH.
REQ-018 DONE: start=1 -> accept new operands exactly as in IDLE and go RUN (back-to-back, one-cycle gap); start=0 -> go IDLE.
REQ-019 start, a, b, cin SHALL be ignored while in RUN; operand input changes mid-operation SHALL NOT affect the result.
REQ-020 s and c SHALL change only on the edge entering DONE; they hold the previous result throughout RUN and IDLE.
REQ-021 Counter width SHALL be clog2(WIDTH)+1 bits; WIDTH=1 SHALL complete in one RUN cycle.
REQ-022 Overflow SHALL not be flagged separately; c carries the unsigned carry-out.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, s=0, c=0, clear counter, carry FF and shift registers; rst has priority over start.
REQ-024 rst asserted mid-RUN SHALL abandon the operation with no done pulse; s/c read 0 afterwards.

Verification (WIDTH=4 unless noted)
REQ-025 a=0, b=0, cin=0, start one cycle -> busy high 4 cycles, done pulse one cycle later, s=4'h0, c=0.
REQ-026 a=4'hF, b=4'h1, cin=0 -> s=4'h0, c=1; then a=4'hF, b=4'hF, cin=1 -> s=4'hF, c=1.
REQ-027 start held high with a=4'h3, b=4'h4 during RUN, a/b changed to 4'hF mid-run -> single result s=4'h7, c=0; no restart until DONE.
REQ-028 Back-to-back: start high in DONE cycle with a=4'h2, b=4'h5 -> second done exactly 5 cycles after first, s=4'h7; s holds first result during second RUN.
REQ-029 rst pulsed at RUN cycle 2 -> no done, busy=0, s=0, c=0 next cycle; subsequent start completes normally.
REQ-030 Exhaustive sweep of all a, b, cin (512 cases) for WIDTH=4, plus random sweep for WIDTH=1 and WIDTH=16 -> {c,s} equals a+b+cin every case; $monitor log of a, b, s, c with time.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, LSB first.
// An addition takes WIDTH cycles in RUN, followed by a single DONE cycle.
//   clk   : clock, rising edge
//   rst   : synchronous, active-high reset
//   start : begin an addition (sampled in IDLE or DONE)
//   a, b  : operands, cin: carry-in (sampled with start)
//   busy  : high in RUN
//   done  : one-cycle pulse when s/c have just been updated
//   s, c  : registered sum and carry-out of a+b+cin
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] sum_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, c_q;
  logic             fa_sum, fa_carry, last_bit;

  // Full-adder cell on the operand LSBs.
  always_comb begin
    fa_sum   = opa_q[0] ^ opb_q[0] ^ carry_q;
    fa_carry = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // Internal sum shift register keeps only the WIDTH-1 bits already produced;
  // the bit being produced now completes the word, so no register bit is ever
  // shifted out unused and WIDTH=1 needs no storage at all.
  if (WIDTH == 1) begin : g_w1
    always_comb sum_d = fa_sum;
  end else begin : g_wn
    logic [WIDTH-2:0] sum_q;

    always_comb sum_d = {fa_sum, sum_q};

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
      end else if (state_q == RUN) begin
        sum_q <= sum_d[WIDTH-1:1];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand load, serial shifting, result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            opa_q   <= a;
            opb_q   <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          carry_q <= fa_carry;
          cnt_q   <= cnt_q + 1'b1;
          if (last_bit) begin
            s_q <= sum_d;
            c_q <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    s    = s_q;
    c    = c_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        start4, cin4, busy4, done4, c4;
  logic [3:0]  a4, b4, s4;
  logic        start1, cin1, busy1, done1, c1;
  logic [0:0]  a1, b1, s1;
  logic        start16, cin16, busy16, done16, c16;
  logic [15:0] a16, b16, s16;

  int checks   = 0;
  int failures = 0;

  logic [4:0] sb[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       c;
  } vec_t;

  vec_t vt[8];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .s(s4), .c(c4)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .s(s1), .c(c1)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .s(s16), .c(c16)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse of the WIDTH=4 adder retires one expectation.
  always @(negedge clk) begin : sb_check
    logic [4:0] e;
    if (done4) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=done_pulse required=no_pulse at %0t", $time);
      end else begin
        e = sb.pop_front();
        chkv("sb_result", 32'({c4, s4}), 32'(e));
      end
    end
  end

  // One addition on the WIDTH=4 adder with exact cycle-by-cycle timing checks.
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                     input logic [3:0] es, input logic ec, input string nm);
    a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
    sb.push_back(5'(ta) + 5'(tb) + 5'(tc));
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1({nm, "_busy"}, busy4, 1'b1);
      chk1({nm, "_nodone"}, done4, 1'b0);
      tick();
    end
    chk1({nm, "_done"}, done4, 1'b1);
    chk1({nm, "_busy_off"}, busy4, 1'b0);
    chkv({nm, "_s"}, 32'(s4), 32'(es));
    chk1({nm, "_c"}, c4, ec);
    tick();
    chk1({nm, "_pulse_end"}, done4, 1'b0);
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    logic [4:0] m;
    m = 5'(ta) + 5'(tb) + 5'(tc);
    a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
    sb.push_back(m);
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 20 && !done4; k++) tick();
    chk1("w4_sweep_done", done4, 1'b1);
    chkv("w4_sweep_sum", 32'({c4, s4}), 32'(m));
    tick();
  endtask

  task automatic run1(input logic ta, input logic tb, input logic tc);
    logic [1:0] m;
    m = 2'(ta) + 2'(tb) + 2'(tc);
    a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk1("w1_busy", busy1, 1'b1);
    tick();
    chk1("w1_done", done1, 1'b1);
    chkv("w1_sum", 32'({c1, s1}), 32'(m));
    tick();
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    logic [16:0] m;
    m = 17'(ta) + 17'(tb) + 17'(tc);
    a16 = ta; b16 = tb; cin16 = tc; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int k = 0; k < 40 && !done16; k++) tick();
    chk1("w16_done", done16, 1'b1);
    chkv("w16_sum", 32'({c16, s16}), 32'(m));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    $monitor("%0t a=%h b=%h s=%h c=%b", $time, a4, b4, s4, c4);
  end

  initial begin
    vt[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    vt[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
    vt[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vt[3] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0};
    vt[4] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0};
    vt[5] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1};
    vt[6] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0};
    vt[7] = '{4'h9, 4'h9, 1'b1, 4'h3, 1'b1};

    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    tick();
    tick();
    chk1("rst_busy", busy4, 1'b0);
    chk1("rst_done", done4, 1'b0);
    chkv("rst_s", 32'(s4), 32'h0);
    chk1("rst_c", c4, 1'b0);
    rst = 1'b0;
    tick();

    foreach (vt[i]) begin
      op4(vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].c, $sformatf("vec%0d", i));
    end

    // start held high through RUN with operands changing mid-run.
    a4 = 4'h3; b4 = 4'h4; cin4 = 1'b0; start4 = 1'b1;
    sb.push_back(5'h07);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk1("hold_busy", busy4, 1'b1);
      chk1("hold_nodone", done4, 1'b0);
      chkv("hold_s_prev", 32'(s4), 32'h3);
      if (k == 1) begin
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
      end
      tick();
    end
    chk1("hold_done", done4, 1'b1);
    chkv("hold_s", 32'(s4), 32'h7);
    chk1("hold_c", c4, 1'b0);
    start4 = 1'b0;
    tick();
    chk1("hold_no_restart", busy4, 1'b0);
    chk1("hold_pulse_end", done4, 1'b0);

    // Back-to-back: new start accepted in the DONE cycle.
    a4 = 4'h1; b4 = 4'h1; cin4 = 1'b0; start4 = 1'b1;
    sb.push_back(5'h02);
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk1("b2b_done1", done4, 1'b1);
    chkv("b2b_s1", 32'(s4), 32'h2);
    a4 = 4'h2; b4 = 4'h5; start4 = 1'b1;
    sb.push_back(5'h07);
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1("b2b_busy2", busy4, 1'b1);
      chkv("b2b_s_hold", 32'(s4), 32'h2);
      tick();
    end
    chk1("b2b_done2", done4, 1'b1);
    chkv("b2b_s2", 32'(s4), 32'h7);
    tick();

    // Reset in RUN cycle 2 abandons the addition.
    a4 = 4'h6; b4 = 4'h6; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("abort_busy", busy4, 1'b0);
    chk1("abort_done", done4, 1'b0);
    chkv("abort_s", 32'(s4), 32'h0);
    chk1("abort_c", c4, 1'b0);
    for (int k = 0; k < 6; k++) begin
      chk1("abort_no_done", done4, 1'b0);
      tick();
    end
    op4(4'h6, 4'h6, 1'b0, 4'hC, 1'b0, "after_rst");

    // Exhaustive WIDTH=4 sweep.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      run4(v[3:0], v[7:4], v[8]);
    end

    // WIDTH=1: exhaustive (8 cases) and a few random repeats.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run1(v[0], v[1], v[2]);
    end
    for (int i = 0; i < 8; i++) begin
      run1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // WIDTH=16: boundaries plus random.
    run16(16'hFFFF, 16'hFFFF, 1'b1);
    run16(16'hFFFF, 16'h0000, 1'b1);
    run16(16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 40; i++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    chkv("sb_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
